// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the clock-divider sequencer.
package clk_seq_pkg;

    localparam int ENTRY_DUR_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        ADVANCE
    } state_t;

    typedef struct packed {
        logic [31:0]            half_count;
        logic [ENTRY_DUR_W-1:0] duration;
    } entry_t;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/clk_div_sequencer_tick.sv
// Down-counting prescaler: one-cycle tick every TICK_DIV enabled cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic tick_o
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RELOAD;
        end else if (enable_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/clk_div_sequencer.sv
// Plays a programmed list of (half_count, duration) entries into the shared clock divider.
// state   | meaning
// IDLE    | waiting for start
// LOAD    | read entry idx, program divider if duration is nonzero
// PLAY    | hold entry for duration ticks
// ADVANCE | pick next entry, wrap when looping, or finish
module clk_div_sequencer
    import clk_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int DUR_W   = ENTRY_DUR_W
) (
    input  logic                       inClk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [31:0]                wr_half_count,
    input  logic [DUR_W-1:0]           wr_duration,
    input  logic [$clog2(DEPTH+1)-1:0] seq_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   cur_index,
    output logic [31:0]                clock_count,
    output logic                       div_reset,
    output logic                       gate
);
    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int IW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge inClk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    // Entry memory is deliberately left out of reset so programs survive a reset.
    entry_t mem_q [DEPTH];
    entry_t rd_entry;

    always_ff @(posedge inClk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= '{half_count: wr_half_count, duration: wr_duration};
        end
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   len_q, len_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [31:0]     cc_q, cc_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            divrst_q, divrst_d;
    logic            gate_q, gate_d;
    logic            presc_clear, tick;

    assign rd_entry = mem_q[idx_q];

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i   (inClk),
        .rst_ni  (rst_sync_q),
        .clear_i (presc_clear),
        .enable_i(state_q == PLAY),
        .tick_o  (tick)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        dur_d       = dur_q;
        cc_d        = cc_q;
        cur_d       = cur_q;
        gate_d      = gate_q;
        done_d      = 1'b0;
        divrst_d    = 1'b0;
        presc_clear = 1'b0;

        if (state_q != IDLE && stop) begin
            state_d  = IDLE;
            gate_d   = 1'b0;
            divrst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (seq_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            len_d   = (int'(seq_len) > DEPTH) ? LW'(DEPTH) : seq_len;
                            idx_d   = '0;
                            cur_d   = '0;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (rd_entry.duration == '0) begin
                        state_d = ADVANCE;
                    end else begin
                        cc_d        = rd_entry.half_count;
                        divrst_d    = 1'b1;
                        gate_d      = (rd_entry.half_count != '0);
                        dur_d       = rd_entry.duration;
                        presc_clear = 1'b1;
                        state_d     = PLAY;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (dur_q == DUR_W'(1)) begin
                            state_d = ADVANCE;
                        end else begin
                            dur_d = dur_q - DUR_W'(1);
                        end
                    end
                end
                ADVANCE: begin
                    if ((LW'(idx_q) + LW'(1)) < len_q) begin
                        idx_d   = idx_q + IW'(1);
                        cur_d   = idx_q + IW'(1);
                        state_d = LOAD;
                    end else if (loop) begin
                        idx_d   = '0;
                        cur_d   = '0;
                        state_d = LOAD;
                    end else begin
                        gate_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge inClk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            dur_q    <= '0;
            cc_q     <= '0;
            cur_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divrst_q <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            dur_q    <= dur_d;
            cc_q     <= cc_d;
            cur_q    <= cur_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            divrst_q <= divrst_d;
            gate_q   <= gate_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cur_index   = cur_q;
    assign clock_count = cc_q;
    assign div_reset   = divrst_q;
    assign gate        = gate_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Bench for clk_div_sequencer: directed and random programs against a timeline model.
module tb_clk_div_sequencer;
    localparam int DEPTH = 4;
    localparam int TD    = 10;

    logic        inClk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0, loop = 1'b0, start = 1'b0, stop = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_half_count = '0;
    logic [15:0] wr_duration = '0;
    logic [2:0]  seq_len = '0;
    logic        busy, done, div_reset, gate;
    logic [1:0]  cur_index;
    logic [31:0] clock_count;

    logic        wr_en_b = 1'b0, start_b = 1'b0;
    logic [1:0]  wr_addr_b = '0, seq_len_b = '0;
    logic        busy_b, done_b, div_reset_b, gate_b;
    logic [1:0]  cur_index_b;
    logic [31:0] clock_count_b;

    always #5 inClk = ~inClk;

    clk_div_sequencer #(.DEPTH(4), .CLK_HZ(1000), .TICK_HZ(100), .DUR_W(16)) dut (
        .inClk(inClk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_half_count(wr_half_count), .wr_duration(wr_duration), .seq_len(seq_len),
        .loop(loop), .start(start), .stop(stop), .busy(busy), .done(done),
        .cur_index(cur_index), .clock_count(clock_count), .div_reset(div_reset), .gate(gate)
    );

    clk_div_sequencer #(.DEPTH(3), .CLK_HZ(1000), .TICK_HZ(100), .DUR_W(16)) dut_b (
        .inClk(inClk), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_half_count(wr_half_count), .wr_duration(wr_duration), .seq_len(seq_len_b),
        .loop(loop), .start(start_b), .stop(1'b0), .busy(busy_b), .done(done_b),
        .cur_index(cur_index_b), .clock_count(clock_count_b), .div_reset(div_reset_b), .gate(gate_b)
    );

    int n_err = 0;
    int n_checks = 0;
    string cur_test = "reset";

    // Reference: memory contents, held divider outputs, and an expected per-cycle timeline.
    int m_half[DEPTH];
    int m_dur[DEPTH];
    int m_cc = 0, m_cur = 0;
    bit m_gate = 0;

    typedef struct {
        bit busy; bit done; bit dr; bit gate; int cc; int cur;
    } smp_t;
    smp_t exp_q[$];

    int opt_stop_at, opt_wr_at, opt_wr_addr, opt_wr_h, opt_wr_d, opt_bstart_at;
    bit opt_start_stop, opt_stop_rand;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s/%s observed=%0d expected=%0d", cur_test, tag, obs, exp_v);
        end
    endtask

    function automatic void push(bit b, bit d, bit r, bit g, int c, int cu);
        smp_t s;
        s.busy = b; s.done = d; s.dr = r; s.gate = g; s.cc = c; s.cur = cu;
        exp_q.push_back(s);
    endfunction

    // Sample k is taken just after the k-th clock edge following the start edge.
    function automatic void build(int len, bit lp, int max_visits);
        int h[DEPTH];
        int d[DEPTH];
        int L, i, visits, c;
        bit g;
        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin h[a] = m_half[a]; d[a] = m_dur[a]; end
        c = m_cc; g = m_gate;
        if (len == 0) begin
            push(0, 1, 0, g, c, m_cur);
            push(0, 0, 0, g, c, m_cur);
            return;
        end
        L = (len > DEPTH) ? DEPTH : len;
        i = 0; visits = 0;
        forever begin
            if (opt_wr_at >= 0 && opt_wr_at < exp_q.size()) begin
                h[opt_wr_addr] = opt_wr_h; d[opt_wr_addr] = opt_wr_d;
            end
            push(1, 0, 0, g, c, i);
            if (d[i] != 0) begin
                c = h[i]; g = (h[i] != 0);
                push(1, 0, 1, g, c, i);
                repeat (d[i] * TD - 1) push(1, 0, 0, g, c, i);
            end
            push(1, 0, 0, g, c, i);
            visits++;
            if (lp && visits >= max_visits) break;
            if (i < L - 1) i++;
            else if (lp) i = 0;
            else begin
                push(0, 1, 0, 0, c, i);
                push(0, 0, 0, 0, c, i);
                break;
            end
        end
    endfunction

    function automatic void apply_stop();
        smp_t last;
        while (exp_q.size() > opt_stop_at + 1) void'(exp_q.pop_back());
        last = exp_q[$];
        push(0, 0, 1, 0, last.cc, last.cur);
        push(0, 0, 0, 0, last.cc, last.cur);
    endfunction

    task automatic clear_opts();
        opt_stop_at = -1; opt_wr_at = -1; opt_bstart_at = -1;
        opt_start_stop = 0; opt_stop_rand = 0;
        opt_wr_addr = 0; opt_wr_h = 0; opt_wr_d = 0;
    endtask

    task automatic wr(input int a, input int h, input int d);
        wr_en = 1; wr_addr = 2'(a); wr_half_count = 32'(h); wr_duration = 16'(d);
        @(posedge inClk); #1;
        wr_en = 0;
        m_half[a] = h; m_dur[a] = d;
    endtask

    task automatic play(input int len, input bit lp, input int visits);
        int k;
        smp_t last;
        build(len, lp, visits);
        if (opt_stop_rand) begin
            k = int'($urandom_range(0, exp_q.size() - 1));
            if (exp_q[k].busy) opt_stop_at = k;
        end
        if (opt_stop_at >= 0) apply_stop();
        seq_len = 3'(len); loop = lp; start = 1; stop = opt_start_stop;
        @(posedge inClk); #1;
        for (int s = 0; s < exp_q.size(); s++) begin
            chk($sformatf("busy@%0d", s), 64'(busy), 64'(exp_q[s].busy));
            chk($sformatf("done@%0d", s), 64'(done), 64'(exp_q[s].done));
            chk($sformatf("div_reset@%0d", s), 64'(div_reset), 64'(exp_q[s].dr));
            chk($sformatf("gate@%0d", s), 64'(gate), 64'(exp_q[s].gate));
            chk($sformatf("clock_count@%0d", s), 64'(clock_count), 64'(exp_q[s].cc));
            chk($sformatf("cur_index@%0d", s), 64'(cur_index), 64'(exp_q[s].cur));
            start = 0; stop = 0; wr_en = 0;
            if (s == opt_stop_at) stop = 1;
            if (s == opt_wr_at) begin
                wr_en = 1; wr_addr = 2'(opt_wr_addr);
                wr_half_count = 32'(opt_wr_h); wr_duration = 16'(opt_wr_d);
                m_half[opt_wr_addr] = opt_wr_h; m_dur[opt_wr_addr] = opt_wr_d;
            end
            if (s == opt_bstart_at) begin
                start = 1; seq_len = 3'($urandom_range(1, 7));
            end
            @(posedge inClk); #1;
        end
        start = 0; stop = 0; wr_en = 0;
        last = exp_q[$];
        m_cc = last.cc; m_gate = last.gate; m_cur = last.cur;
    endtask

    task automatic chk_all_zero();
        chk("busy", 64'(busy), 0);
        chk("done", 64'(done), 0);
        chk("div_reset", 64'(div_reset), 0);
        chk("gate", 64'(gate), 0);
        chk("clock_count", 64'(clock_count), 0);
        chk("cur_index", 64'(cur_index), 0);
    endtask

    initial begin
        int got[$];
        int exp_b[3];
        bit seen_done;
        clear_opts();

        reset_n = 0;
        repeat (3) @(posedge inClk);
        #1 chk_all_zero();
        reset_n = 1;
        repeat (4) @(posedge inClk);
        #1;

        cur_test = "three_entries";
        wr(0, 25, 2); wr(1, 50, 1); wr(2, 10, 3);
        play(3, 0, 100);

        cur_test = "loop_then_stop";
        clear_opts(); opt_stop_at = 93;
        play(3, 1, 5);

        cur_test = "write_while_playing";
        clear_opts(); opt_stop_at = 93;
        opt_wr_at = 27; opt_wr_addr = 1; opt_wr_h = 77; opt_wr_d = 1;
        play(3, 1, 5);

        cur_test = "rest_and_skip";
        clear_opts();
        wr(0, 0, 2); wr(1, 40, 0); wr(2, 30, 1);
        play(3, 0, 100);

        cur_test = "len_zero";
        clear_opts();
        play(0, 0, 100);

        cur_test = "start_while_busy";
        clear_opts(); opt_bstart_at = 5;
        wr(0, 25, 2); wr(1, 50, 1); wr(2, 10, 3);
        play(3, 0, 100);

        cur_test = "start_with_stop_idle";
        clear_opts(); opt_start_stop = 1;
        play(2, 0, 100);

        cur_test = "reset_mid_play";
        seq_len = 3; loop = 0; start = 1;
        @(posedge inClk); #1 start = 0;
        repeat (8) @(posedge inClk);
        #3 reset_n = 0;
        #1 chk_all_zero();
        m_cc = 0; m_gate = 0; m_cur = 0;
        repeat (2) @(posedge inClk);
        #1 reset_n = 1;
        repeat (4) @(posedge inClk);
        #1;
        cur_test = "replay_after_reset";
        clear_opts();
        play(3, 0, 100);

        for (int it = 0; it < 6; it++) begin
            cur_test = $sformatf("random%0d", it);
            for (int a = 0; a < DEPTH; a++)
                wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 500)),
                   int'($urandom_range(0, 2)));
            clear_opts(); opt_stop_rand = 1;
            if ($urandom_range(0, 1) == 1) begin
                opt_wr_at = int'($urandom_range(0, 40));
                opt_wr_addr = int'($urandom_range(0, DEPTH - 1));
                opt_wr_h = int'($urandom_range(0, 500));
                opt_wr_d = int'($urandom_range(0, 2));
            end
            play(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 6);
        end

        cur_test = "depth3_addr_oob";
        loop = 0;
        exp_b[0] = 11; exp_b[1] = 22; exp_b[2] = 33;
        for (int a = 0; a < 4; a++) begin
            wr_en_b = 1; wr_addr_b = 2'(a);
            wr_half_count = (a < 3) ? 32'(exp_b[a]) : 32'd99;
            wr_duration = 16'd1;
            @(posedge inClk); #1;
        end
        wr_en_b = 0;
        seq_len_b = 2'd3; start_b = 1;
        @(posedge inClk); #1 start_b = 0;
        seen_done = 0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (div_reset_b) got.push_back(int'(clock_count_b));
            if (done_b) seen_done = 1;
            @(posedge inClk); #1;
        end
        chk("done_seen", 64'(seen_done), 1);
        chk("pulse_count", 64'(got.size()), 3);
        for (int i = 0; i < 3; i++)
            if (i < got.size()) chk($sformatf("cc%0d", i), 64'(got[i]), 64'(exp_b[i]));
        chk("busy_after", 64'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
